load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of WAIT cycles without mem_ack before the access is aborted.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  3  RISC-V funct3: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle pulse marking completion.
REQ-011 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 resp_err  output  1  misaligned access, illegal size, or timeout.
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  32  word-aligned address {req_addr[31:2],2'b00}.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_be  output  4  byte-lane enables.
REQ-018 mem_rdata  input  32  memory read word, valid with mem_ack.
REQ-019 mem_ack  input  1  memory completion, sampled only in WAIT.

Function
REQ-020 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 exactly when state is IDLE.
REQ-021 A request SHALL be accepted on a clock edge with req_valid=1 and req_ready=1; req_addr, req_size, req_we and req_wdata are captured at that edge.
REQ-022 A legal, aligned request SHALL move IDLE->WAIT, driving mem_en=1 and registered mem_we, mem_addr, mem_be and mem_wdata from the next cycle; these outputs SHALL remain stable throughout WAIT.
REQ-023 mem_be SHALL be 4'b0001<<addr[1:0] for bytes, 4'b0011<<addr[1:0] for halves, and 4'b1111 for words.
REQ-024 mem_wdata SHALL be {4{wdata[7:0]}} for bytes, {2{wdata[15:0]}} for halves, and wdata for words.
REQ-025 Misaligned requests SHALL go IDLE->RESP with no memory access (mem_en stays 0), then respond with resp_err=1 and resp_rdata=0; misaligned means a half with addr[0]=1 or a word with addr[1:0]!=0.
REQ-026 Illegal sizes SHALL be handled the same way as misaligned requests; illegal means 011, 110 or 111, and for stores also 100 or 101.
REQ-027 In WAIT, mem_ack=1 SHALL move to RESP, deassert mem_en on the following cycle, and register the extracted load data.
REQ-028 Load extraction SHALL shift mem_rdata right by 8*addr[1:0], then sign-extend from bit 7/15 for sizes 000/001 or zero-extend for 100/101; words pass unchanged.
REQ-029 A WAIT cycle counter SHALL start at 0; if TIMEOUT cycles elapse without mem_ack, the FSM SHALL go to RESP with resp_err=1 and resp_rdata=0 and drop mem_en.
REQ-030 RESP SHALL last exactly one cycle, with resp_valid=1, and then return to IDLE; there is no response backpressure.
REQ-031 Minimum load/store latency SHALL be 2 cycles from the accept edge to resp_valid (ack in first WAIT cycle); an error response SHALL occur 1 cycle after accept.
REQ-032 mem_ack outside WAIT SHALL be ignored, and req_valid outside IDLE SHALL not be captured.
REQ-033 For stores, resp_rdata SHALL be 0 and resp_err SHALL be 0 on a successful ack.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE, set mem_en, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_err, resp_rdata and the timeout counter to 0, and set req_ready to 1.
REQ-035 Reset mid-WAIT SHALL drop the access with no response; a later mem_ack SHALL be ignored.

Verification
REQ-036 Store byte: addr=0x00000013, size=000, wdata=0x000000AB -> mem_addr=0x10, mem_be=1000, mem_wdata=0xABABABAB, mem_we=1; ack -> resp_valid with err=0.
REQ-037 Load half signed: addr=0x22, size=001, mem_rdata=0x8001_0000 with ack in first WAIT cycle -> resp_rdata=0xFFFF8001 exactly 2 cycles after accept; the same access with size=101 -> 0x00008001.
REQ-038 Misaligned word: addr=0x06, size=010 -> mem_en never asserted, resp_valid=1, resp_err=1 one cycle after accept.
REQ-039 Timeout: load with mem_ack held 0 and TIMEOUT=16 -> mem_en high 16 cycles, then resp_err=1, rdata=0, and req_ready back to 1 on the next cycle.
REQ-040 Reset mid-WAIT: assert rst asynchronously -> mem_en=0 before the next edge, no resp_valid, and a mem_ack after reset release has no effect.
REQ-041 Back-to-back: req_valid held high for two word loads -> the second is accepted only after the first RESP cycle, and mem_addr is stable across each WAIT.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding memory access with byte-lane steering,
// load extension, alignment/size checks and an ack timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [1:0]         off, off_n;
  logic [2:0]         size, size_n;
  logic               mem_en_n, mem_we_n;
  logic [31:0]        mem_addr_n, mem_wdata_n;
  logic [3:0]         mem_be_n;
  logic               resp_valid_n, resp_err_n;
  logic [31:0]        resp_rdata_n;

  logic               req_bad;
  logic [3:0]         req_be;
  logic [31:0]        req_lanes;
  logic [31:0]        rd_shift;
  logic [31:0]        load_data;

  assign req_ready = (state == IDLE);

  // Request legality: illegal encodings (stores may not use unsigned sizes) or misalignment
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      3'b000:         req_bad = 1'b0;
      3'b001:         req_bad = req_addr[0];
      3'b010:         req_bad = (req_addr[1:0] != 2'b00);
      3'b100:         req_bad = req_we;
      3'b101:         req_bad = req_we | req_addr[0];
      default:        req_bad = 1'b1;
    endcase
  end

  // Byte-lane enables and replicated store data
  always_comb begin
    req_be    = 4'b1111;
    req_lanes = req_wdata;
    case (req_size[1:0])
      2'b00: begin
        req_be    = 4'b0001 << req_addr[1:0];
        req_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be    = 4'b0011 << req_addr[1:0];
        req_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_lanes = req_wdata;
      end
    endcase
  end

  // Load extraction from the captured offset and size
  always_comb begin
    rd_shift = mem_rdata >> {off, 3'b000};
    case (size)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_data = {24'd0, rd_shift[7:0]};
      3'b101:  load_data = {16'd0, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    off_n        = off;
    size_n       = size;
    mem_en_n     = mem_en;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    mem_be_n     = mem_be;
    resp_valid_n = 1'b0;
    resp_err_n   = 1'b0;
    resp_rdata_n = 32'd0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          off_n  = req_addr[1:0];
          size_n = req_size;
          cnt_n  = '0;
          if (req_bad) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
          end else begin
            state_n     = WAIT;
            mem_en_n    = 1'b1;
            mem_we_n    = req_we;
            mem_addr_n  = {req_addr[31:2], 2'b00};
            mem_be_n    = req_be;
            mem_wdata_n = req_lanes;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_n      = RESP;
          mem_en_n     = 1'b0;
          resp_valid_n = 1'b1;
          resp_rdata_n = mem_we ? 32'd0 : load_data;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n      = RESP;
          mem_en_n     = 1'b0;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n  = IDLE;
        mem_en_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      off        <= 2'd0;
      size       <= 3'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_be     <= 4'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      off        <= off_n;
      size       <= size_n;
      mem_en     <= mem_en_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_be     <= mem_be_n;
      resp_valid <= resp_valid_n;
      resp_err   <= resp_err_n;
      resp_rdata <= resp_rdata_n;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  // Legal access acked in its first WAIT cycle
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [3:0] be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    present(we, size, addr, wdata);
    check({tag, "_en"}, 32'(mem_en), 32'd1);
    check({tag, "_we"}, 32'(mem_we), 32'(we));
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    check({tag, "_be"}, 32'(mem_be), 32'(be));
    if (we) check({tag, "_wdata"}, mem_wdata, exp_wd);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    check({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
    check({tag, "_rerr"}, 32'(resp_err), 32'd0);
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_en_off"}, 32'(mem_en), 32'd0);
    tick();
    check({tag, "_rvalid_off"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  // Rejected request: immediate error response, no memory strobe
  task automatic reject(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr);
    present(we, size, addr, 32'h5555_AAAA);
    check({tag, "_en"}, 32'(mem_en), 32'd0);
    check({tag, "_rvalid"}, 32'(resp_valid), 32'd1);
    check({tag, "_rerr"}, 32'(resp_err), 32'd1);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    tick();
    check({tag, "_en2"}, 32'(mem_en), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    check({tag, "_rvalid_off"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int n;
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_en", 32'(mem_en), 32'd0);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    access("st_b",   1'b1, 3'b000, 32'h0000_0013, 32'h0000_00AB, 32'h0,         4'b1000, 32'hABAB_ABAB, 32'h0);
    access("ld_h",   1'b0, 3'b001, 32'h0000_0022, 32'h0,         32'h8001_0000, 4'b1100, 32'h0,         32'hFFFF_8001);
    access("ld_hu",  1'b0, 3'b101, 32'h0000_0022, 32'h0,         32'h8001_0000, 4'b1100, 32'h0,         32'h0000_8001);
    access("ld_b",   1'b0, 3'b000, 32'h0000_0041, 32'h0,         32'h1234_F678, 4'b0010, 32'h0,         32'hFFFF_FFF6);
    access("ld_bu",  1'b0, 3'b100, 32'h0000_0041, 32'h0,         32'h1234_F678, 4'b0010, 32'h0,         32'h0000_00F6);
    access("ld_w",   1'b0, 3'b010, 32'h0000_0044, 32'h0,         32'hDEAD_BEEF, 4'b1111, 32'h0,         32'hDEAD_BEEF);
    access("st_h",   1'b1, 3'b001, 32'h0000_0002, 32'h1234_5678, 32'hFFFF_FFFF, 4'b1100, 32'h5678_5678, 32'h0);
    access("st_w",   1'b1, 3'b010, 32'h0000_0080, 32'hCAFE_F00D, 32'h0,         4'b1111, 32'hCAFE_F00D, 32'h0);
    access("ld_b3",  1'b0, 3'b100, 32'h0000_0063, 32'h0,         32'h7F00_0000, 4'b1000, 32'h0,         32'h0000_007F);

    reject("mis_w",  1'b0, 3'b010, 32'h0000_0006);
    reject("mis_h",  1'b0, 3'b001, 32'h0000_0001);
    reject("ill_3",  1'b0, 3'b011, 32'h0000_0000);
    reject("ill_7",  1'b1, 3'b111, 32'h0000_0000);
    reject("ill_sbu", 1'b1, 3'b100, 32'h0000_0000);
    reject("ill_shu", 1'b1, 3'b101, 32'h0000_0000);

    // Timeout: no ack for the whole WAIT window
    mem_rdata = 32'hFFFF_FFFF;
    present(1'b0, 3'b010, 32'h0000_0008, 32'h0);
    n = 0;
    while (mem_en && n < 40) begin
      n++;
      tick();
    end
    check("to_cycles", 32'(n), 32'd16);
    check("to_rvalid", 32'(resp_valid), 32'd1);
    check("to_rerr", 32'(resp_err), 32'd1);
    check("to_rdata", resp_rdata, 32'd0);
    check("to_ready_resp", 32'(req_ready), 32'd0);
    tick();
    check("to_ready_back", 32'(req_ready), 32'd1);
    check("to_rvalid_off", 32'(resp_valid), 32'd0);

    // Asynchronous reset in the middle of WAIT, then a stray ack
    present(1'b0, 3'b010, 32'h0000_0030, 32'h0);
    check("rw_en", 32'(mem_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rw_en_async", 32'(mem_en), 32'd0);
    check("rw_ready_async", 32'(req_ready), 32'd1);
    tick();
    rst     = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rw_no_resp", 32'(resp_valid), 32'd0);
      check("rw_no_en", 32'(mem_en), 32'd0);
    end
    mem_ack = 1'b0;

    // Back-to-back word loads with req_valid held high
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 3'b010;
    req_addr  = 32'h0000_0100;
    tick();
    req_addr = 32'h0000_0200;
    check("bb1_addr", mem_addr, 32'h0000_0100);
    check("bb1_ready", 32'(req_ready), 32'd0);
    tick();
    check("bb1_addr_hold", mem_addr, 32'h0000_0100);
    check("bb1_en_hold", 32'(mem_en), 32'd1);
    mem_rdata = 32'h1111_1111;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("bb1_rvalid", 32'(resp_valid), 32'd1);
    check("bb1_rdata", resp_rdata, 32'h1111_1111);
    check("bb1_ready_resp", 32'(req_ready), 32'd0);
    tick();
    check("bb_gap_ready", 32'(req_ready), 32'd1);
    check("bb_gap_en", 32'(mem_en), 32'd0);
    tick();
    req_valid = 1'b0;
    check("bb2_en", 32'(mem_en), 32'd1);
    check("bb2_addr", mem_addr, 32'h0000_0200);
    mem_rdata = 32'h2222_2222;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("bb2_rvalid", 32'(resp_valid), 32'd1);
    check("bb2_rdata", resp_rdata, 32'h2222_2222);
    tick();
    check("bb2_ready_back", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
